// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   funct3 encodings for RV32I loads/stores, FSM state encodings,
//   store byte-lane masks and a helper that places a mask on its lanes.
package lsu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned F3_W = 3;
  localparam int unsigned RD_W = 5;
  localparam int unsigned BE_W = 4;

  // Load funct3
  localparam logic [F3_W-1:0] LB  = 3'b000;
  localparam logic [F3_W-1:0] LH  = 3'b001;
  localparam logic [F3_W-1:0] LW  = 3'b010;
  localparam logic [F3_W-1:0] LBU = 3'b100;
  localparam logic [F3_W-1:0] LHU = 3'b101;

  // Store funct3
  localparam logic [F3_W-1:0] SB  = 3'b000;
  localparam logic [F3_W-1:0] SH  = 3'b001;
  localparam logic [F3_W-1:0] SW  = 3'b010;

  // Store byte-lane masks before lane shift
  localparam logic [BE_W-1:0] MASK_B = 4'b0001;
  localparam logic [BE_W-1:0] MASK_H = 4'b0011;
  localparam logic [BE_W-1:0] MASK_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Byte enables for a store; halves only land on lanes 0/2, words on lane 0.
  function automatic logic [BE_W-1:0] store_mask(input logic [F3_W-1:0] f3,
                                                 input logic [1:0]      off);
    logic [BE_W-1:0] m;
    case (f3)
      SB:      m = BE_W'(MASK_B << off);
      SH:      m = BE_W'(MASK_H << {off[1], 1'b0});
      default: m = MASK_W;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load-data extraction and extension.
//   i_dout   : raw 32-bit word from data memory
//   i_off    : byte offset (addr[1:0]) of the load
//   i_funct3 : load funct3 (LB/LH/LW/LBU/LHU)
//   o_data_c : aligned, sign/zero-extended result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] i_dout,
  input  logic [1:0]      i_off,
  input  logic [F3_W-1:0] i_funct3,
  output logic [XLEN-1:0] o_data_c
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = 8'h00;
    w_half   = 16'h0000;
    o_data_c = i_dout;

    case (i_off)
      2'd0:    w_byte = i_dout[7:0];
      2'd1:    w_byte = i_dout[15:8];
      2'd2:    w_byte = i_dout[23:16];
      default: w_byte = i_dout[31:24];
    endcase

    // Half selection ignores addr[0]: halves come from lanes 0 or 2 only.
    w_half = i_off[1] ? i_dout[31:16] : i_dout[15:0];

    case (i_funct3)
      LB:      o_data_c = {{24{w_byte[7]}}, w_byte};
      LBU:     o_data_c = {24'h000000, w_byte};
      LH:      o_data_c = {{16{w_half[15]}}, w_half};
      LHU:     o_data_c = {16'h0000, w_half};
      default: o_data_c = i_dout;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one memory op at a time, IDLE -> REQ -> (RESP) -> IDLE.
//   clk, rst          : clock, asynchronous active-high reset
//   ex_*              : op from execute (valid/ready handshake)
//   dmem_*            : single-cycle request to word-addressed data memory,
//                       read data returns one cycle after the request
//   wb_*              : one-cycle load result to writeback
//   misalign          : one-cycle pulse for a rejected misaligned access
// Optional feature: define LSU_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses; otherwise misalign is 0 and low address bits
// beyond the access size are ignored.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [XLEN-1:0]   ex_addr,
  input  logic [XLEN-1:0]   ex_wdata,
  input  logic [F3_W-1:0]   ex_funct3,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [RD_W-1:0]   ex_rd,
  output logic              dmem_en,
  output logic [BE_W-1:0]   dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [XLEN-1:0]   dmem_din,
  input  logic [XLEN-1:0]   dmem_dout,
  output logic              wb_valid,
  output logic [XLEN-1:0]   wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              misalign
);

  lsu_state_e        r_state;
  logic              r_ex_ready;
  logic              r_is_load;
  logic [F3_W-1:0]   r_funct3;
  logic [1:0]        r_off;
  logic [RD_W-1:0]   r_rd;
  logic              r_dmem_en;
  logic [BE_W-1:0]   r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [XLEN-1:0]   r_dmem_din;
  logic              r_wb_valid;
  logic [XLEN-1:0]   r_wb_data;
  logic [RD_W-1:0]   r_wb_rd;
  logic              r_misalign;

  logic              w_load_ok;
  logic              w_store_ok;
  logic              w_misal;
  logic [XLEN-1:0]   w_st_data;
  logic [XLEN-1:0]   w_ld_data;

  // Op classification; load wins when both class bits are set.
  always_comb begin
    w_load_ok  = ex_is_load && (ex_funct3 == LB  || ex_funct3 == LH ||
                                ex_funct3 == LW  || ex_funct3 == LBU ||
                                ex_funct3 == LHU);
    w_store_ok = !ex_is_load && ex_is_store && (ex_funct3 <= SW);
`ifdef LSU_MISALIGN_CHECK_EN
    w_misal = (w_load_ok || w_store_ok) &&
              (((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)) ||
               ((ex_funct3[1:0] == 2'b01) && ex_addr[0]));
`else
    w_misal = 1'b0;
`endif
  end

  // Store data replicated across lanes so any lane enable picks it up.
  always_comb begin
    case (ex_funct3[1:0])
      2'b00:   w_st_data = {4{ex_wdata[7:0]}};
      2'b01:   w_st_data = {2{ex_wdata[15:0]}};
      default: w_st_data = ex_wdata;
    endcase
  end

  lsu_load_align u_load_align (
    .i_dout   (dmem_dout),
    .i_off    (r_off),
    .i_funct3 (r_funct3),
    .o_data_c (w_ld_data)
  );

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ex_ready  <= 1'b1;
      r_is_load   <= 1'b0;
      r_funct3    <= '0;
      r_off       <= '0;
      r_rd        <= '0;
      r_dmem_en   <= 1'b0;
      r_dmem_we   <= '0;
      r_dmem_addr <= '0;
      r_dmem_din  <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_rd     <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_dmem_en  <= 1'b0;
      r_dmem_we  <= '0;
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;

      case (r_state)
        IDLE: begin
          // Invalid or unclassified ops are accepted and dropped here.
          if (ex_valid) begin
            if (w_misal) begin
              r_misalign <= 1'b1;
            end else if (w_load_ok || w_store_ok) begin
              r_is_load   <= w_load_ok;
              r_funct3    <= ex_funct3;
              r_off       <= ex_addr[1:0];
              r_rd        <= ex_rd;
              r_dmem_en   <= 1'b1;
              r_dmem_we   <= w_store_ok ? store_mask(ex_funct3, ex_addr[1:0]) : '0;
              r_dmem_addr <= ex_addr[ADDR_W+1:2];
              r_dmem_din  <= w_st_data;
              r_ex_ready  <= 1'b0;
              r_state     <= REQ;
            end
          end
        end
        REQ: begin
          if (r_is_load) begin
            r_state <= RESP;
          end else begin
            r_ex_ready <= 1'b1;
            r_state    <= IDLE;
          end
        end
        RESP: begin
          r_wb_data  <= w_ld_data;
          r_wb_rd    <= r_rd;
          r_wb_valid <= 1'b1;
          r_ex_ready <= 1'b1;
          r_state    <= IDLE;
        end
        default: begin
          r_ex_ready <= 1'b1;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  assign ex_ready  = r_ex_ready;
  assign dmem_en   = r_dmem_en;
  assign dmem_we   = r_dmem_we;
  assign dmem_addr = r_dmem_addr;
  assign dmem_din  = r_dmem_din;
  assign wb_valid  = r_wb_valid;
  assign wb_data   = r_wb_data;
  assign wb_rd     = r_wb_rd;
  assign misalign  = r_misalign;

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu. Outputs are sampled 1ns after the
// rising edge; inputs are changed at the same point.
module tb_lsu;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [2:0]  ex_funct3;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [4:0]  ex_rd;
  logic        dmem_en;
  logic [3:0]  dmem_we;
  logic [29:0] dmem_addr;
  logic [31:0] dmem_din;
  logic [31:0] dmem_dout;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        misalign;

  int n_cmp = 0;
  int n_bad = 0;

  lsu #(.ADDR_W(30)) dut (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_ready    (ex_ready),
    .ex_addr     (ex_addr),
    .ex_wdata    (ex_wdata),
    .ex_funct3   (ex_funct3),
    .ex_is_load  (ex_is_load),
    .ex_is_store (ex_is_store),
    .ex_rd       (ex_rd),
    .dmem_en     (dmem_en),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_din    (dmem_din),
    .dmem_dout   (dmem_dout),
    .wb_valid    (wb_valid),
    .wb_data     (wb_data),
    .wb_rd       (wb_rd),
    .misalign    (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (n_cmp=%0d)", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    ex_valid    = 1'b1;
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = addr;
    ex_wdata    = wd;
    ex_rd       = rd;
  endtask

  // Present an op for one edge (the accept edge), then drop ex_valid.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rd);
    drive(ld, st, f3, addr, wd, rd);
    tick();
    ex_valid = 1'b0;
  endtask

  // Load: REQ cycle, RESP cycle, then wb cycle (third cycle after accept).
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] dout, input logic [4:0] rd,
                         input logic [31:0] exp);
    dmem_dout = dout;
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd);
    chk({tag, "_req_en"},   32'(dmem_en), 32'd1);
    chk({tag, "_req_we"},   32'(dmem_we), 32'd0);
    chk({tag, "_req_addr"}, 32'(dmem_addr), 32'(addr[31:2]));
    tick();
    chk({tag, "_resp_en"},  32'(dmem_en), 32'd0);
    chk({tag, "_resp_wbv"}, 32'(wb_valid), 32'd0);
    tick();
    chk({tag, "_wbv"},      32'(wb_valid), 32'd1);
    chk({tag, "_wbdata"},   wb_data, exp);
    chk({tag, "_wbrd"},     32'(wb_rd), 32'(rd));
    tick();
    chk({tag, "_wbv_off"},  32'(wb_valid), 32'd0);
    chk({tag, "_hold"},     wb_data, exp);
  endtask

  // Store: one REQ cycle with the write, then back in IDLE.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [3:0] exp_we,
                          input logic [31:0] exp_din);
    issue(1'b0, 1'b1, f3, addr, wd, 5'd0);
    chk({tag, "_en"},    32'(dmem_en), 32'd1);
    chk({tag, "_we"},    32'(dmem_we), 32'(exp_we));
    chk({tag, "_addr"},  32'(dmem_addr), 32'(addr[31:2]));
    chk({tag, "_din"},   dmem_din, exp_din);
    chk({tag, "_rdy0"},  32'(ex_ready), 32'd0);
    tick();
    chk({tag, "_en_off"}, 32'(dmem_en), 32'd0);
    chk({tag, "_we_off"}, 32'(dmem_we), 32'd0);
    chk({tag, "_rdy1"},  32'(ex_ready), 32'd1);
    chk({tag, "_nowb"},  32'(wb_valid), 32'd0);
  endtask

  // Op that must be swallowed in IDLE with no memory access.
  task automatic do_drop(input string tag, input logic ld, input logic st,
                         input logic [2:0] f3, input logic [31:0] addr);
    issue(ld, st, f3, addr, 32'h12345678, 5'd1);
    chk({tag, "_en"},   32'(dmem_en), 32'd0);
    chk({tag, "_rdy"},  32'(ex_ready), 32'd1);
    tick();
    chk({tag, "_en2"},  32'(dmem_en), 32'd0);
    chk({tag, "_nowb"}, 32'(wb_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_addr = '0; ex_wdata = '0; ex_funct3 = '0;
    ex_is_load = 1'b0; ex_is_store = 1'b0; ex_rd = '0; dmem_dout = '0;
    tick();
    tick();
    chk("rst_ready",  32'(ex_ready), 32'd1);
    chk("rst_en",     32'(dmem_en), 32'd0);
    chk("rst_we",     32'(dmem_we), 32'd0);
    chk("rst_wbv",    32'(wb_valid), 32'd0);
    chk("rst_mis",    32'(misalign), 32'd0);
    chk("rst_wbdata", wb_data, 32'd0);
    chk("rst_wbrd",   32'(wb_rd), 32'd0);
    chk("rst_addr",   32'(dmem_addr), 32'd0);
    chk("rst_din",    dmem_din, 32'd0);
    rst = 1'b0;
    tick();

    do_store("sw100", 3'd2, 32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    do_store("sb103", 3'd0, 32'h103, 32'h000000A5, 4'b1000, 32'hA5A5A5A5);
    do_store("sb101", 3'd0, 32'h101, 32'h0000FF3C, 4'b0010, 32'h3C3C3C3C);
    do_store("sh102", 3'd1, 32'h202, 32'hAAAA1234, 4'b1100, 32'h12341234);

    do_load("lb102",  3'd0, 32'h102, 32'h00800000, 5'd5,  32'hFFFFFF80);
    do_load("lbu102", 3'd4, 32'h102, 32'h00800000, 5'd7,  32'h00000080);
    do_load("lh102",  3'd1, 32'h102, 32'hBEEF1234, 5'd10, 32'hFFFFBEEF);
    do_load("lhu100", 3'd5, 32'h100, 32'hBEEF1234, 5'd11, 32'h00001234);
    do_load("lw104",  3'd2, 32'h104, 32'hCAFEBABE, 5'd31, 32'hCAFEBABE);
    do_load("lb101",  3'd0, 32'h101, 32'h00007F00, 5'd2,  32'h0000007F);

    // Both class bits set behaves as a load.
    do_drop_skip: begin end
    dmem_dout = 32'h13579BDF;
    issue(1'b1, 1'b1, 3'd2, 32'h108, 32'hFFFFFFFF, 5'd4);
    chk("both_en", 32'(dmem_en), 32'd1);
    chk("both_we", 32'(dmem_we), 32'd0);
    tick();
    tick();
    chk("both_wbv",  32'(wb_valid), 32'd1);
    chk("both_data", wb_data, 32'h13579BDF);
    tick();

    do_drop("noclass", 1'b0, 1'b0, 3'd2, 32'h100);
    do_drop("ld_f3_3", 1'b1, 1'b0, 3'd3, 32'h100);
    do_drop("ld_f3_6", 1'b1, 1'b0, 3'd6, 32'h100);
    do_drop("ld_f3_7", 1'b1, 1'b0, 3'd7, 32'h100);
    do_drop("st_f3_4", 1'b0, 1'b1, 3'd4, 32'h100);
    chk("drop_wbhold", wb_data, 32'h13579BDF);

`ifdef LSU_MISALIGN_CHECK_EN
    issue(1'b1, 1'b0, 3'd2, 32'h101, 32'h0, 5'd6);
    chk("mis_lw_pulse", 32'(misalign), 32'd1);
    chk("mis_lw_en",    32'(dmem_en), 32'd0);
    chk("mis_lw_rdy",   32'(ex_ready), 32'd1);
    tick();
    chk("mis_lw_pulse_off", 32'(misalign), 32'd0);
    chk("mis_lw_en2",   32'(dmem_en), 32'd0);
    chk("mis_lw_nowb",  32'(wb_valid), 32'd0);
    issue(1'b0, 1'b1, 3'd1, 32'h203, 32'h0, 5'd0);
    chk("mis_sh_pulse", 32'(misalign), 32'd1);
    chk("mis_sh_en",    32'(dmem_en), 32'd0);
    tick();
    chk("mis_sh_off",   32'(misalign), 32'd0);
`else
    // Low bits beyond access size ignored: word from lane 0, half from lane 2.
    do_load("lw101", 3'd2, 32'h101, 32'h89ABCDEF, 5'd6, 32'h89ABCDEF);
    chk("nomis_flag", 32'(misalign), 32'd0);
    do_load("lhu103", 3'd5, 32'h103, 32'hBEEF1234, 5'd8, 32'h0000BEEF);
    do_store("sw102", 3'd2, 32'h102, 32'h01020304, 4'b1111, 32'h01020304);
    do_store("sh101", 3'd1, 32'h101, 32'h0000ABCD, 4'b0011, 32'hABCDABCD);
    chk("nomis_flag2", 32'(misalign), 32'd0);
`endif

    // Back-to-back: lh held valid, then sw presented while busy.
    dmem_dout = 32'h0000F00D;
    drive(1'b1, 1'b0, 3'd1, 32'h100, 32'h0, 5'd9);
    tick();
    drive(1'b0, 1'b1, 3'd2, 32'h200, 32'h11223344, 5'd0);
    chk("b2b_req_rdy", 32'(ex_ready), 32'd0);
    chk("b2b_req_we",  32'(dmem_we), 32'd0);
    tick();
    chk("b2b_resp_rdy", 32'(ex_ready), 32'd0);
    chk("b2b_resp_en",  32'(dmem_en), 32'd0);
    tick();
    chk("b2b_wbv",  32'(wb_valid), 32'd1);
    chk("b2b_rd",   32'(wb_rd), 32'd9);
    chk("b2b_data", wb_data, 32'hFFFFF00D);
    chk("b2b_rdy",  32'(ex_ready), 32'd1);
    chk("b2b_en0",  32'(dmem_en), 32'd0);
    tick();
    ex_valid = 1'b0;
    chk("b2b_sw_en",   32'(dmem_en), 32'd1);
    chk("b2b_sw_we",   32'(dmem_we), 32'hF);
    chk("b2b_sw_addr", 32'(dmem_addr), 32'h80);
    chk("b2b_sw_din",  dmem_din, 32'h11223344);
    chk("b2b_sw_wbv",  32'(wb_valid), 32'd0);
    tick();
    chk("b2b_idle", 32'(ex_ready), 32'd1);

    // Reset while in RESP of an lw aborts the writeback.
    dmem_dout = 32'h55AA55AA;
    issue(1'b1, 1'b0, 3'd2, 32'h104, 32'h0, 5'd3);
    tick();
    rst = 1'b1;
    #1;
    chk("rstresp_wbv", 32'(wb_valid), 32'd0);
    chk("rstresp_rdy", 32'(ex_ready), 32'd1);
    chk("rstresp_wbd", wb_data, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstresp_wbv2", 32'(wb_valid), 32'd0);
    chk("rstresp_rdy2", 32'(ex_ready), 32'd1);
    tick();
    chk("rstresp_wbv3", 32'(wb_valid), 32'd0);

    // Reset during REQ of a store kills the write enable at once.
    issue(1'b0, 1'b1, 3'd2, 32'h300, 32'h77777777, 5'd0);
    chk("rstreq_en_pre", 32'(dmem_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstreq_en", 32'(dmem_en), 32'd0);
    chk("rstreq_we", 32'(dmem_we), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("rstreq_en2", 32'(dmem_en), 32'd0);
    chk("rstreq_rdy", 32'(ex_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
